turf_trig_rx: RTL
=================

// Module: turf_trig_rx
// PURPOSE
//  Receiver end of the SURF trigger stream. Accepts 32-bit AXI4-Stream trigger words from the SURF
//  trigger generator FIFO, validates framing, extracts address/metadata, gates on run state and
//  buffers events in a 2-entry output FIFO for the TURF trigger merger. Keeps saturating event counters.
// PARAMETERS
//  COUNT_W      16   width of trig/err/drop counters (saturating)
//  FLUSH_CLKS   64   ifclk cycles to keep accepting words after runstop_i (in-flight drain), 1..255
// PORTS
//  ifclk          in   1   clock (all logic single-domain)
//  aresetn        in   1   asynchronous active-low reset
//  s_trig_tdata   in   32  trigger word {2'b10, addr[11:0], 2'b00, 8'h00, meta[7:0]}
//  s_trig_tvalid  in   1   AXI4-S valid
//  s_trig_tready  out  1   AXI4-S ready
//  runrst_i       in   1   run start pulse
//  runstop_i      in   1   run stop pulse
//  trig_valid_o   out  1   event available
//  trig_ready_i   in   1   downstream accepts event
//  trig_addr_o    out  12  event address (tdata[29:18])
//  trig_meta_o    out  8   event metadata (tdata[7:0])
//  frame_err_o    out  1   1-cycle pulse: malformed word accepted
//  running_o      out  1   1 in RUNNING or FLUSH
//  trig_count_o   out  COUNT_W  good events written to output FIFO
//  err_count_o    out  COUNT_W  malformed words
//  drop_count_o   out  COUNT_W  well-formed words discarded (stopped or output overflow impossible, see below)
// BEHAVIOUR
//  Reset (aresetn=0, async): state=STOPPED, FIFO empty, trig_valid_o=0, frame_err_o=0, running_o=0,
//   all counters 0, addr/meta outputs 0, flush counter 0. s_trig_tready=1 after reset.
//  Handshake: word accepted when s_trig_tvalid && s_trig_tready. Well-formed iff tdata[31:30]==2'b10,
//   tdata[17:16]==0, tdata[15:8]==0. Malformed: err_count++, frame_err_o pulses next cycle, never queued.
//  States:
//   STOPPED: tready=1 (upstream drains). Well-formed accepts -> drop_count++, discarded.
//   RUNNING: tready = FIFO not full (count<2). Well-formed accept -> FIFO write, trig_count++.
//   FLUSH:   as RUNNING; flush counter loads FLUSH_CLKS-1 on entry, decrements; at 0 -> STOPPED.
//  Transitions: runrst_i from any state -> RUNNING; also empties output FIFO and clears all three
//   counters that cycle (a word accepted that same cycle is discarded, not counted). runstop_i in
//   RUNNING -> FLUSH; in FLUSH/STOPPED ignored. runrst_i && runstop_i same cycle: runrst_i wins.
//  Output FIFO: 2 entries {addr,meta}; head presented on trig_addr_o/trig_meta_o while trig_valid_o.
//   Latency: word accepted at edge N -> trig_valid_o=1 after edge N+1 if FIFO was empty. Pop on
//   trig_valid_o && trig_ready_i. Simultaneous push+pop at count 2 cannot occur (tready=0 when full);
//   at count 1 push+pop keeps count 1, new head next cycle. Outputs hold stable while valid && !ready.
//   FIFO contents persist through FLUSH->STOPPED; downstream may keep popping in STOPPED.
//  Counters saturate at all-ones; no wrap. Addresses passed verbatim (12-bit, wrap owned upstream).
//  No combinational path s_trig_tvalid -> s_trig_tready or trig_ready_i -> s_trig_tready; tready is
//   registered from next-state FIFO count/state.
// TESTING
//  1 Reset, no runrst; send 3 words 0x8048_0011 -> tready=1 throughout, drop_count=3, trig_valid_o=0.
//  2 runrst; send 0x8048_0011 (addr 0x012, meta 0x11) with trig_ready_i=1 -> trig_valid_o one cycle
//    after accept, addr=0x012 meta=0x11, trig_count=1.
//  3 RUNNING, trig_ready_i=0, stream 4 words -> 2 queued, tready=0 after 2nd; release ready -> events
//    pop in order, remaining 2 accepted, trig_count=4, none lost.
//  4 Words 0x4000_0000, 0x8001_0000, 0x8000_0100 -> 3 frame_err_o pulses, err_count=3, no events.
//  5 runstop then words at +10 and +FLUSH_CLKS+5 cycles -> first counted, second dropped; running_o
//    falls exactly FLUSH_CLKS cycles after runstop.
//  6 runrst and runstop same cycle while FIFO holds 1 event -> RUNNING, FIFO empty, counters 0.
//  7 Drive err/trig counts past 2^COUNT_W-1 (COUNT_W=4 build) -> hold at 15.

Source files
------------

// File: rtl/turf_trig_rx.sv
`default_nettype none
// ============================================================================
// Module   : turf_trig_rx
// Purpose  : SURF trigger-stream receiver. Checks word framing, gates events
//            on run state and queues them for the TURF trigger merger.
// Revision : 1.0 - initial release
// ============================================================================
module turf_trig_rx #(
  parameter int COUNT_W    = 16,
  parameter int FLUSH_CLKS = 64
) (
  input  logic               ifclk,
  input  logic               aresetn,
  input  logic [31:0]        s_trig_tdata,
  input  logic               s_trig_tvalid,
  output logic               s_trig_tready,
  input  logic               runrst_i,
  input  logic               runstop_i,
  output logic               trig_valid_o,
  input  logic               trig_ready_i,
  output logic [11:0]        trig_addr_o,
  output logic [7:0]         trig_meta_o,
  output logic               frame_err_o,
  output logic               running_o,
  output logic [COUNT_W-1:0] trig_count_o,
  output logic [COUNT_W-1:0] err_count_o,
  output logic [COUNT_W-1:0] drop_count_o
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  localparam logic [7:0] c_flush_load = 8'(FLUSH_CLKS - 1);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_flush_cnt, w_flush_nxt;
  logic               r_tready, w_tready_nxt;
  logic               r_frame_err;
  logic               r_stage_vld;
  logic [19:0]        r_stage_data;
  logic [19:0]        r_mem [2];
  logic               r_wr_ptr, r_rd_ptr;
  logic [1:0]         r_fifo_cnt, w_fifo_cnt_nxt;
  logic [2:0]         w_occ_nxt;
  logic [COUNT_W-1:0] r_trig_cnt, r_err_cnt, r_drop_cnt;
  logic               w_accept, w_well, w_push, w_pop;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_accept = s_trig_tvalid & r_tready;
  assign w_well   = (s_trig_tdata[31:30] == 2'b10) && (s_trig_tdata[17:16] == 2'b00) &&
                    (s_trig_tdata[15:8] == 8'h00);
  // Accepted good words pass through a one-entry stage before the FIFO.
  assign w_push   = w_accept && w_well && (r_state != ST_STOPPED) && !runrst_i;
  assign w_pop    = (r_fifo_cnt != 2'd0) && trig_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    if (runrst_i) begin
      w_state_nxt = ST_RUNNING;
      w_flush_nxt = 8'd0;
    end else begin
      case (r_state)
        ST_STOPPED: w_state_nxt = ST_STOPPED;
        ST_RUNNING: begin
          if (runstop_i) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = c_flush_load;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 8'd0) w_state_nxt = ST_STOPPED;
          else                     w_flush_nxt = r_flush_cnt - 8'd1;
        end
        default: w_state_nxt = ST_STOPPED;
      endcase
    end
  end

  // Ready is a register fed from next-cycle occupancy (stage + FIFO).
  always_comb begin
    w_fifo_cnt_nxt = 2'd0;
    if (!runrst_i)
      w_fifo_cnt_nxt = 2'(r_fifo_cnt + {1'b0, r_stage_vld} - {1'b0, w_pop});
    w_occ_nxt    = {1'b0, w_fifo_cnt_nxt} + {2'b00, w_push};
    w_tready_nxt = (w_state_nxt == ST_STOPPED) || (w_occ_nxt < 3'd2);
  end

  always_ff @(posedge ifclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ST_STOPPED;
      r_flush_cnt  <= 8'd0;
      r_tready     <= 1'b1;
      r_frame_err  <= 1'b0;
      r_stage_vld  <= 1'b0;
      r_stage_data <= 20'd0;
      r_mem[0]     <= 20'd0;
      r_mem[1]     <= 20'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_fifo_cnt   <= 2'd0;
      r_trig_cnt   <= '0;
      r_err_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_tready    <= w_tready_nxt;
      r_frame_err <= w_accept && !w_well && !runrst_i;
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      if (runrst_i) begin
        r_stage_vld <= 1'b0;
        r_wr_ptr    <= 1'b0;
        r_rd_ptr    <= 1'b0;
        r_trig_cnt  <= '0;
        r_err_cnt   <= '0;
        r_drop_cnt  <= '0;
      end else begin
        r_stage_vld <= w_push;
        if (w_push) r_stage_data <= {s_trig_tdata[29:18], s_trig_tdata[7:0]};
        if (r_stage_vld) begin
          r_mem[r_wr_ptr] <= r_stage_data;
          r_wr_ptr        <= ~r_wr_ptr;
          r_trig_cnt      <= sat_inc(r_trig_cnt);
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        if (w_accept && !w_well) r_err_cnt <= sat_inc(r_err_cnt);
        if (w_accept && w_well && (r_state == ST_STOPPED)) r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end
  end

  assign s_trig_tready = r_tready;
  assign trig_valid_o  = (r_fifo_cnt != 2'd0);
  assign trig_addr_o   = r_mem[r_rd_ptr][19:8];
  assign trig_meta_o   = r_mem[r_rd_ptr][7:0];
  assign frame_err_o   = r_frame_err;
  assign running_o     = (r_state != ST_STOPPED);
  assign trig_count_o  = r_trig_cnt;
  assign err_count_o   = r_err_cnt;
  assign drop_count_o  = r_drop_cnt;

endmodule
`default_nettype wire
